// File: rtl/nios2_pio_pkg.sv
// Shared constants for the bidirectional PIO: register word addresses and edge-type codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nios2_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/nios2_bidir_pio_if.sv
// Avalon-MM slave bus bundle for the PIO: address, select, write strobe, data in and out.
// Latency: readdata is registered by the slave, valid one cycle after address.
// Backpressure: none; the slave accepts every access with no wait states.
interface nios2_bidir_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios2_pio_sync.sv
// Two-flop pin synchronizer with optional per-bit stability filter (PIO_DEBOUNCE_EN).
// Latency: 2 cycles; plus DEB_CYCLES when the filter is built.
// Backpressure: none; samples every cycle.
module nios2_pio_sync
  import nios2_pio_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("DEB_CYCLES out of range 1..255");
  end

  logic [WIDTH-1:0] s1, s2;

  // Metastability guard: two back-to-back flops on the raw pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  logic [7:0]       cnt [WIDTH];
  logic [WIDTH-1:0] filt;

  // Accept a new level only after it has held for DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] != filt[i]) begin
          if (cnt[i] == 8'(DEB_CYCLES - 1)) begin
            filt[i] <= s2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign q = filt;
`else
  assign q = s2;
`endif

endmodule

// File: rtl/nios2_bidir_pio.sv
// WIDTH-bit bidirectional Avalon PIO: direction, set/clear, edge capture, masked irq (PIO_DEBOUNCE_EN adds filter).
// Latency: read 1 cycle; write to pin 1 cycle; pin to DATA/EDGECAP 3 cycles (+DEB_CYCLES filtered).
// Backpressure: none; zero wait states, every access completes.
module nios2_bidir_pio
  import nios2_pio_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int          EDGE_TYPE  = 2,
  parameter logic [31:0] RESET_DIR  = 32'h0,
  parameter logic [31:0] RESET_OUT  = 32'h0,
  parameter int          DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  nios2_bidir_pio_if.slave  bus,
  inout  wire [WIDTH-1:0]   bidir_port,
  output logic              irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH out of range 1..32");
  end

  logic [WIDTH-1:0] data_out, dir, irq_mask, edge_cap;
  logic [WIDTH-1:0] in_s, in_d, edge_hit, cap_clr, wd;
  logic [1:0]       arm;
  logic [31:0]      rd_mux;
  logic             wr;

  assign wr = bus.chipselect & ~bus.write_n;
  assign wd = bus.writedata[WIDTH-1:0];

  nios2_pio_sync #(.WIDTH(WIDTH), .DEB_CYCLES(DEB_CYCLES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bidir_port),
    .q       (in_s)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
  end

  // Host-visible control registers, including atomic set/clear of data_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT[WIDTH-1:0];
      dir      <= RESET_DIR[WIDTH-1:0];
      irq_mask <= '0;
    end else if (wr) begin
      case (bus.address)
        ADDR_DATA:    data_out <= wd;
        ADDR_DIR:     dir      <= wd;
        ADDR_IRQMASK: irq_mask <= wd;
        ADDR_OUTSET:  data_out <= data_out | wd;
        ADDR_OUTCLR:  data_out <= data_out & ~wd;
        default:      ;
      endcase
    end
  end

  // Edge qualification; suppressed until the sync pipeline holds real pin samples.
  always_comb begin
    edge_hit = '0;
    if (arm == 2'd3) begin
      if (EDGE_TYPE == int'(EDGE_RISE))      edge_hit = in_s & ~in_d;
      else if (EDGE_TYPE == int'(EDGE_FALL)) edge_hit = ~in_s & in_d;
      else                                   edge_hit = in_s ^ in_d;
    end
  end

  assign cap_clr = (wr && bus.address == ADDR_EDGECAP) ? wd : '0;

  // Delay line, arm counter and sticky capture; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_d     <= '0;
      arm      <= '0;
      edge_cap <= '0;
    end else begin
      in_d     <= in_s;
      if (arm != 2'd3) arm <= arm + 2'd1;
      edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
    end
  end

  // Read mux, decoded from the address alone; unused bits and addresses read zero.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:    rd_mux = 32'(in_s);
      ADDR_DIR:     rd_mux = 32'(dir);
      ADDR_IRQMASK: rd_mux = 32'(irq_mask);
      ADDR_EDGECAP: rd_mux = 32'(edge_cap);
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data, loaded every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_mux;
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios2_bidir_pio.sv
// Bench for nios2_bidir_pio: two instances (rising-edge and any-edge) share one stimulus stream.
// A sample-history model predicts readdata, irq and pins every cycle; literal checks pin the model.
// Inputs driven 2ns after posedge, outputs compared on negedge.
module tb_nios2_bidir_pio;
  import nios2_pio_pkg::*;

  localparam int W = 8;
  localparam int DEB = 4;
`ifdef PIO_DEBOUNCE_EN
  localparam int          XLAT     = 3 + DEB;
  localparam logic [31:0] BOOT_CAP = 32'hF5;
`else
  localparam int          XLAT     = 3;
  localparam logic [31:0] BOOT_CAP = 32'h00;
`endif

  logic        clk, reset_n;
  logic [2:0]  address;
  logic        cs, wn;
  logic [31:0] wd;
  logic [7:0]  tb_drv;
  wire  [7:0]  pins0, pins1;
  wire         irq0, irq1;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0] m_dout, m_dir, m_mask, m_cap_r, m_cap_a, m_rd_r, m_rd_a;
  logic [7:0] ph [0:2];
  logic [7:0] fil, fil_prev;
  int         run [W];
  int         nedge;
  logic       model_on = 1'b0;
  logic [7:0] l_pin, l_wd;
  logic       l_wr;
  logic [2:0] l_addr;

  wire [7:0] tb_en   = ~m_dir;
  wire [7:0] exp_pin = (m_dir & m_dout) | (~m_dir & tb_drv);

  nios2_bidir_pio_if bus0 ();
  nios2_bidir_pio_if bus1 ();
  assign bus0.address = address;  assign bus1.address = address;
  assign bus0.chipselect = cs;    assign bus1.chipselect = cs;
  assign bus0.write_n = wn;       assign bus1.write_n = wn;
  assign bus0.writedata = wd;     assign bus1.writedata = wd;

  for (genvar i = 0; i < W; i++) begin : g_drv
    assign pins0[i] = tb_en[i] ? tb_drv[i] : 1'bz;
    assign pins1[i] = tb_en[i] ? tb_drv[i] : 1'bz;
  end

  nios2_bidir_pio #(.WIDTH(W), .EDGE_TYPE(0), .RESET_DIR(32'h0F), .RESET_OUT(32'h05),
                    .DEB_CYCLES(DEB)) u_rise (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .bidir_port(pins0), .irq(irq0));

  nios2_bidir_pio #(.WIDTH(W), .EDGE_TYPE(2), .RESET_DIR(32'h0F), .RESET_OUT(32'h05),
                    .DEB_CYCLES(DEB)) u_any (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .bidir_port(pins1), .irq(irq1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_dout = 8'h05; m_dir = 8'h0F; m_mask = 8'h00;
    m_cap_r = 8'h00; m_cap_a = 8'h00; m_rd_r = 8'h00; m_rd_a = 8'h00;
    for (int k = 0; k < 3; k++) ph[k] = 8'h00;
    fil = 8'h00; fil_prev = 8'h00; nedge = 0;
    for (int k = 0; k < W; k++) run[k] = 0;
  endtask

  // Advance the model across one clock edge using the inputs latched before it.
  task automatic model_step();
    logic [7:0] cur, prev, rise, fall, clr, nfil;
`ifdef PIO_DEBOUNCE_EN
    cur = fil; prev = fil_prev;
`else
    cur = ph[1]; prev = ph[2];
`endif
    rise = (nedge >= 3) ? (cur & ~prev) : 8'h00;
    fall = (nedge >= 3) ? (~cur & prev) : 8'h00;
    clr  = (l_wr && l_addr == 3'd3) ? l_wd : 8'h00;
    case (l_addr)
      3'd0:    begin m_rd_r = cur;     m_rd_a = cur;     end
      3'd1:    begin m_rd_r = m_dir;   m_rd_a = m_dir;   end
      3'd2:    begin m_rd_r = m_mask;  m_rd_a = m_mask;  end
      3'd3:    begin m_rd_r = m_cap_r; m_rd_a = m_cap_a; end
      default: begin m_rd_r = 8'h00;   m_rd_a = 8'h00;   end
    endcase
    m_cap_r = (m_cap_r & ~clr) | rise;
    m_cap_a = (m_cap_a & ~clr) | rise | fall;
    if (l_wr) begin
      case (l_addr)
        3'd0: m_dout = l_wd;
        3'd1: m_dir  = l_wd;
        3'd2: m_mask = l_wd;
        3'd4: m_dout = m_dout | l_wd;
        3'd5: m_dout = m_dout & ~l_wd;
        default: ;
      endcase
    end
    nfil = fil;
    for (int k = 0; k < W; k++) begin
      if (ph[1][k] != fil[k]) run[k] = run[k] + 1;
      else                    run[k] = 0;
      if (run[k] >= DEB) begin nfil[k] = ph[1][k]; run[k] = 0; end
    end
    fil_prev = fil; fil = nfil;
    ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = l_pin;
    if (nedge < 3) nedge++;
  endtask

  always @(negedge reset_n) reset_model();

  always @(posedge clk) begin
    #1;
    if (reset_n) model_step();
  end

  // Per-cycle comparison against the model, then latch inputs for the next edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("rd_rise",   bus0.readdata, {24'h0, m_rd_r});
      chk("rd_any",    bus1.readdata, {24'h0, m_rd_a});
      chk("irq_rise",  {31'h0, irq0}, {31'h0, |(m_cap_r & m_mask)});
      chk("irq_any",   {31'h0, irq1}, {31'h0, |(m_cap_a & m_mask)});
      chk("pins_rise", {24'h0, pins0}, {24'h0, exp_pin});
      chk("pins_any",  {24'h0, pins1}, {24'h0, exp_pin});
    end
    l_pin  = exp_pin;
    l_wr   = cs & ~wn;
    l_addr = address;
    l_wd   = wd[7:0];
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    address = a; cs = 1'b1; wn = 1'b0; wd = d;
    @(posedge clk); #2;
    cs = 1'b0; wn = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e0, input logic [31:0] e1, input string nm);
    @(posedge clk); #2;
    address = a;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_rise"}, bus0.readdata, e0);
    chk({nm, "_any"},  bus1.readdata, e1);
  endtask

  task automatic settle();
    repeat (XLAT + 3) @(posedge clk);
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; cs = 1'b0; wn = 1'b1; wd = 32'h0;
    tb_drv = 8'hF0;
    reset_model();
    model_on = 1'b1;
    @(negedge clk);
    chk("reset_pins_lo", {28'h0, pins0[3:0]}, 32'h5);
    chk("reset_rd", bus0.readdata, 32'h0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // reset values and register map, inputs pulled high
    repeat (10) @(posedge clk);
    rd(3'd3, BOOT_CAP, BOOT_CAP, "boot_cap");
    rd(3'd0, 32'hF5, 32'hF5, "boot_data");
    rd(3'd1, 32'h0F, 32'h0F, "boot_dir");
    rd(3'd2, 32'h00, 32'h00, "boot_mask");
    for (int a = 4; a < 8; a++) rd(3'(a), 32'h0, 32'h0, "boot_hole");

    // direction, data, set and clear
    wr(3'd1, 32'hFF);
    wr(3'd0, 32'hFFFF_FFA0);
    wr(3'd4, 32'h0C);
    wr(3'd5, 32'h80);
    @(negedge clk);
    chk("pins_2c", {24'h0, pins0}, 32'h2C);
    settle();
    rd(3'd0, 32'h2C, 32'h2C, "data_2c");

    // rising edge capture timing and irq
    @(posedge clk); #2 tb_drv = 8'h00;
    wr(3'd1, 32'h00);
    settle();
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h01);
    @(posedge clk); #2 address = 3'd3;
    @(posedge clk); #2 tb_drv[0] = 1'b1;
    repeat (XLAT - 1) @(posedge clk);
    @(negedge clk);
    chk("irq_before", {31'h0, irq0}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("irq_on_edge", {31'h0, irq0}, 32'h1);
    rd(3'd3, 32'h01, 32'h01, "cap_rise");
    @(posedge clk); #2 tb_drv[0] = 1'b0;
    settle();
    rd(3'd3, 32'h01, 32'h01, "cap_after_fall");
    wr(3'd3, 32'h01);
    @(negedge clk);
    chk("irq_cleared", {31'h0, irq0}, 32'h0);

    // edge and clear land on the same clock edge
    @(posedge clk); #2 tb_drv[0] = 1'b1;
    settle();
    @(posedge clk); #2 tb_drv[0] = 1'b0;
    settle();
    @(posedge clk); #2 tb_drv[0] = 1'b1;
    repeat (XLAT - 2) @(posedge clk);
    wr(3'd3, 32'h01);
    @(negedge clk);
    chk("set_wins_irq", {31'h0, irq0}, 32'h1);
    rd(3'd3, 32'h01, 32'h01, "set_wins_cap");

    // capture with mask off, then unmask
    wr(3'd2, 32'h00);
    wr(3'd3, 32'hFF);
    @(posedge clk); #2 tb_drv = 8'h13;
    settle();
    @(posedge clk); #2 tb_drv = 8'h02;
    settle();
    rd(3'd3, 32'h12, 32'h13, "cap_masked");
    chk("irq_masked", {31'h0, irq1}, 32'h0);
    wr(3'd2, 32'hFF);
    @(negedge clk);
    chk("irq_unmask", {31'h0, irq1}, 32'h1);

`ifdef PIO_DEBOUNCE_EN
    // short glitch rejected, held change accepted
    @(posedge clk); #2 tb_drv[6] = 1'b1;
    repeat (3) @(posedge clk);
    #2 tb_drv[6] = 1'b0;
    settle();
    rd(3'd3, 32'h12, 32'h13, "glitch_cap");
    @(posedge clk); #2 tb_drv[6] = 1'b1;
    settle();
    rd(3'd3, 32'h52, 32'h53, "deb_cap");
    rd(3'd0, 32'h42, 32'h42, "deb_data");
`endif

    // asynchronous reset mid-operation
    @(posedge clk); #2 reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_pins", {28'h0, pins0[3:0]}, 32'h5);
    chk("midrst_rd", bus0.readdata, 32'h0);
    chk("midrst_irq", {31'h0, irq0}, 32'h0);
    @(posedge clk); #2 reset_n = 1'b1;
    settle();
    rd(3'd1, 32'h0F, 32'h0F, "post_rst_dir");
    rd(3'd2, 32'h00, 32'h00, "post_rst_mask");

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
